// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
//
// Shares one byte-wide RAM port between instruction fetch (IF) and the MEM
// stage's data accesses. The controller takes a 32-bit request with a 4-bit
// byte-lane select and turns it into one RAM cycle per selected byte, visiting
// lanes in ascending address order. Loads are assembled into a word; stores are
// split into bytes. Data requests have fixed priority over fetches, and a
// transaction that has started is never preempted.
//
// Ports
//   clk, rst          rising-edge clock; synchronous active-high reset
//   if_req/if_addr    fetch request and address (always a full word)
//   if_data/if_done   fetched word and its one-cycle completion pulse
//   mem_ce/mem_we     data request strobe and store (1) / load (0) select
//   mem_addr/mem_sel  data address and byte-lane select
//   mem_wdata         store data, already replicated across lanes
//   mem_rdata         load word (unselected lanes read as 0)
//   mem_done          one-cycle completion pulse for the data side
//   busy              high whenever a transaction is in progress
//   ram_a/ram_dout    RAM byte address and write data
//   ram_din           RAM read data, valid one cycle after its address
//   ram_wr            RAM write strobe
// -----------------------------------------------------------------------------
module mem_ctrl #(
   parameter int ADDR_W = 17
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [31:0]       if_addr,
   output logic [31:0]       if_data,
   output logic              if_done,
   input  logic              mem_ce,
   input  logic              mem_we,
   input  logic [31:0]       mem_addr,
   input  logic [3:0]        mem_sel,
   input  logic [31:0]       mem_wdata,
   output logic [31:0]       mem_rdata,
   output logic              mem_done,
   output logic              busy,
   output logic [ADDR_W-1:0] ram_a,
   output logic [7:0]        ram_dout,
   input  logic [7:0]        ram_din,
   output logic              ram_wr
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_WAIT,
      S_DONE
   } state_t;

   state_t state, state_nxt;

   // Grant decision in IDLE (data wins over fetch).
   logic       grant;
   logic [3:0] grant_sel;

   // Transaction context latched at grant time.
   logic              is_fetch;
   logic [ADDR_W-3:0] word_addr;
   logic              we_q;
   logic [31:0]       wdata_q;
   logic [3:0]        pend;        // lanes still to be visited, sel bit order
   logic [31:0]       result;

   // A load address presented last cycle has its byte on ram_din now.
   logic       cap_valid;
   logic [1:0] cap_off;

   // Byte offset being accessed this cycle and the lanes left after it.
   logic [1:0] cur_off;
   logic [3:0] pend_nxt;

   // Byte of a word for a given offset: offset 0 is the most significant byte.
   function automatic logic [7:0] lane_byte(input logic [31:0] word,
                                            input logic [1:0]  off);
      logic [7:0] b;
      case (off)
         2'd0:    b = word[31:24];
         2'd1:    b = word[23:16];
         2'd2:    b = word[15:8];
         default: b = word[7:0];
      endcase
      return b;
   endfunction

   // NOTE: every signal written in an always_comb gets a default first, so no
   // path through the block leaves it unassigned and no latch is inferred.
   always_comb begin
      grant     = mem_ce | if_req;
      grant_sel = mem_ce ? mem_sel : 4'b1111;
   end

   // Lowest pending offset first; sel[3] maps to offset 0.
   always_comb begin
      cur_off = 2'd3;
      casez (pend)
         4'b1???: cur_off = 2'd0;
         4'b01??: cur_off = 2'd1;
         4'b001?: cur_off = 2'd2;
         default: cur_off = 2'd3;
      endcase
      pend_nxt = pend & ~(4'b1000 >> cur_off);
   end

   // ---------------------------------------------------------------- FSM ----
   // NOTE: clocked state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (grant) state_nxt = (grant_sel == 4'b0000) ? S_DONE : S_ACCESS;
         end
         S_ACCESS: begin
            if (pend_nxt == 4'b0000) state_nxt = we_q ? S_DONE : S_WAIT;
         end
         S_WAIT:  state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      ram_wr   = 1'b0;
      ram_a    = '0;
      ram_dout = '0;
      if_done  = 1'b0;
      mem_done = 1'b0;
      busy     = (state != S_IDLE);
      case (state)
         S_ACCESS: begin
            ram_a    = {word_addr, cur_off};
            ram_wr   = we_q;
            ram_dout = we_q ? lane_byte(wdata_q, cur_off) : 8'h00;
         end
         S_DONE: begin
            if_done  = is_fetch;
            mem_done = ~is_fetch;
         end
         default: ;
      endcase
   end

   // Only the requester that owns the result register sees it.
   assign if_data   = is_fetch ? result : 32'h0;
   assign mem_rdata = is_fetch ? 32'h0  : result;

   // ----------------------------------------------------------- datapath ----
   always_ff @(posedge clk) begin
      if (rst) begin
         is_fetch  <= 1'b0;
         word_addr <= '0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
         pend      <= '0;
         result    <= '0;
         cap_valid <= 1'b0;
         cap_off   <= '0;
      end else begin
         cap_valid <= 1'b0;
         // ~offset turns offset 0..3 into byte lane 3..0 of the word.
         if (cap_valid) result[{~cap_off, 3'b000} +: 8] <= ram_din;

         case (state)
            S_IDLE: begin
               if (grant) begin
                  is_fetch  <= ~mem_ce;
                  word_addr <= mem_ce ? mem_addr[ADDR_W-1:2] : if_addr[ADDR_W-1:2];
                  we_q      <= mem_ce & mem_we;
                  wdata_q   <= mem_wdata;
                  pend      <= grant_sel;
                  result    <= '0;
               end
            end
            S_ACCESS: begin
               pend      <= pend_nxt;
               cap_valid <= ~we_q;
               cap_off   <= cur_off;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Sequencing and arbitration controller for the single byte-wide RAM port, shared by instruction fetch (IF) and the MEM stage's data accesses.
- Accepts 32-bit requests with 4-bit byte-lane selects.
- Serialises each request into one RAM cycle per selected byte and assembles or disassembles words.
- Pulses a per-requester done signal on completion; requesters stall until they see it.
- Sits between the IF/MEM pipeline stages and the RAM.

## Interface
- ADDR_W, 17, RAM byte-address width.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- if_req  in  1  fetch request; held stable until if_done.
- if_addr  in  32  fetch address; the access is always a full word (lanes 1111).
- if_data  out  32  fetched word; valid while if_done=1, held until the next grant.
- if_done  out  1  one-cycle completion pulse.
- mem_ce  in  1  data request; held stable until mem_done.
- mem_we  in  1  1 = store, 0 = load.
- mem_addr  in  32  data address.
- mem_sel  in  4  byte-lane select.
- mem_wdata  in  32  store data, already lane-replicated by the MEM stage.
- mem_rdata  out  32  load word; unselected lanes are 0; held until the next grant.
- mem_done  out  1  one-cycle completion pulse.
- busy  out  1  high whenever state≠IDLE.
- ram_a  out  ADDR_W  RAM byte address.
- ram_dout  out  8  RAM write data.
- ram_din  in  8  RAM read data; valid 1 cycle after its address is presented.
- ram_wr  out  1  RAM write strobe.

## Operation
- Lane map:
  - Base address = {addr[ADDR_W-1:2], 2'b00}; addr[1:0] is ignored.
  - sel[3] ↔ offset 0 ↔ bits[31:24]; sel[2] ↔ offset 1 ↔ bits[23:16].
  - sel[1] ↔ offset 2 ↔ bits[15:8]; sel[0] ↔ offset 3 ↔ bits[7:0].
- Selected bytes are accessed in ascending offset order. Unselected offsets are skipped, with no RAM cycle spent on them.
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - If mem_ce=1, grant to data.
  - Otherwise, if if_req=1, grant to fetch.
  - Data has fixed priority over fetch; there is no preemption.
  - On grant, latch the requester's address, sel (1111 for fetch), we and wdata; clear the result register to 0.
  - If the latched sel = 0000, go directly to DONE.
  - Otherwise go to ACCESS with byte counter k = 0.
- ACCESS, one cycle per selected byte:
  - ram_a = base + offset(k).
  - Store: ram_wr = 1, ram_dout = the latched wdata lane for that offset.
  - Load: ram_wr = 0. The byte on ram_din is captured into its lane one cycle after its address.
  - After the last byte, a store goes to DONE and a load goes to WAIT.
- WAIT (loads only): ram_wr = 0, ram_a = 0; capture the last byte; go to DONE.
- DONE:
  - Assert the granted requester's done signal for exactly one cycle; the result is valid.
  - Requests are not sampled in this cycle.
  - Return to IDLE.
  - The requester drops or changes its request at the edge ending DONE.
- Inputs are ignored after latching. Request changes mid-transaction are protocol violations and do not affect the transaction in flight.
- Outside ACCESS: ram_wr = 0, ram_a = 0, ram_dout = 0.

## Timing
Cycle 0 is the IDLE cycle in which the request is sampled; N is the number of selected bytes.
- Store: ram_wr is high in cycles 1..N; done is asserted in cycle N+1.
- Load: addresses are presented in cycles 1..N, WAIT is cycle N+1, and done is asserted in cycle N+2.
- Full-word fetch: done in cycle 6. SW: done in cycle 5. LB: done in cycle 3.
- sel = 0000: done in cycle 1; mem_rdata = 0; no RAM activity.
- Back-to-back requests: the earliest next grant is the IDLE cycle following DONE, which leaves a minimum one-cycle gap between transactions.
- Reset values: state IDLE, if_done = mem_done = 0, if_data = mem_rdata = 0, ram_wr = 0, ram_a = 0, ram_dout = 0, busy = 0.
- Reset mid-transaction:
  - Goes to IDLE at the next edge with no done pulse.
  - Bytes already written stay written.
  - Read data is discarded (the result register is cleared).

## Test plan
- Reset: rst high for 2 cycles with mem_ce = 1, mem_we = 1 → ram_wr = 0, both done = 0, busy = 0, rdata = 0. The request is granted in the first cycle after rst falls.
- Fetch: if_addr = 0x100, RAM[0x100..0x103] = 13 05 10 00 → ram_a = 0x100..0x103 in cycles 1-4; if_done in cycle 6; if_data = 0x13051000.
- SW: mem_addr = 0x204, sel = 1111, wdata = 0xDEADBEEF → writes 0x204 = DE, 0x205 = AD, 0x206 = BE, 0x207 = EF in cycles 1-4; mem_done in cycle 5.
- LB / SH:
  - LB: mem_addr = 0x30A, sel = 0010, RAM[0x30A] = 0x9C → single read at 0x30A; mem_rdata = 0x00009C00; mem_done in cycle 3.
  - SH: mem_addr = 0x402, sel = 0011, wdata = 0x12341234 → 0x402 = 12, 0x403 = 34; mem_done in cycle 3.
- Contention: if_req and an SW (sel = 1111) asserted in the same IDLE cycle → data is served first with mem_done in cycle 5; the fetch is granted in cycle 6 and if_done is asserted in cycle 12.
- Reset mid-fetch: rst asserted in cycle 2 of a fetch → IDLE next cycle; if_done never pulses; if_data = 0; a re-issued fetch completes normally.
